// File: rtl/fp_sub_cdb_unit.sv
// Tomasulo functional-unit wrapper around a combinational FP subtractor core:
// registered operand stage feeding an in-order result queue drained onto the CDB.
module fp_sub_cdb_unit #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  output logic             sa,
  output logic             sb,
  output logic [10:0]      ea,
  output logic [10:0]      eb,
  output logic [51:0]      ma,
  output logic [51:0]      mb,
  input  logic [63:0]      res,
  input  logic [7:0]       flags,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [63:0]      cdb_data,
  output logic [7:0]       cdb_flags,
  output logic             busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
    logic [7:0]       flags;
  } entry_t;

  logic             s1_valid_q, s1_valid_d;
  logic [63:0]      op_a_q, op_a_d;
  logic [63:0]      op_b_q, op_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic             push;
  logic             pop;
  logic             accept;

  // Core operand fields come straight from the stage-1 registers.
  assign sa = op_a_q[63];
  assign ea = op_a_q[62:52];
  assign ma = op_a_q[51:0];
  assign sb = op_b_q[63];
  assign eb = op_b_q[62:52];
  assign mb = op_b_q[51:0];

  assign head      = mem_q[rd_ptr_q];
  assign cdb_valid = (count_q != '0);
  assign cdb_tag   = head.tag;
  assign cdb_data  = head.data;
  assign cdb_flags = head.flags;
  assign busy      = s1_valid_q || (count_q != '0);

  // Handshake, queue control and next-state.
  always_comb begin
    pop        = (count_q != '0) && cdb_grant;
    push       = s1_valid_q && ((count_q < CNT_W'(DEPTH)) || pop);
    in_ready   = !s1_valid_q || push;
    accept     = in_valid && in_ready;
    s1_valid_d = s1_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    s1_tag_d   = s1_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      op_a_d     = in_a;
      op_b_d     = in_b;
      s1_tag_d   = in_tag;
    end else if (push) begin
      s1_valid_d = 1'b0;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset and flush share one squash path; any handshake in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      s1_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      s1_tag_q   <= s1_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) mem_q[wr_ptr_q] <= '{tag: s1_tag_q, data: res, flags: flags};
    end
  end

endmodule

// File: tb/tb_fp_sub_cdb_unit.sv
// Directed + randomized bench for fp_sub_cdb_unit with a behavioral subtractor core
// and an in-order scoreboard of expected CDB results.
module tb_fp_sub_cdb_unit;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, cdb_grant, cdb_valid, busy;
  logic [TAG_W-1:0] in_tag, cdb_tag;
  logic [63:0]      in_a, in_b, res, cdb_data;
  logic             sa, sb;
  logic [10:0]      ea, eb;
  logic [51:0]      ma, mb;
  logic [7:0]       flags, cdb_flags;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
    logic [7:0]       fl;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  logic last_acc;

  always #5 clk = ~clk;

  function automatic logic [63:0] fsub(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) - $bitstoreal(b));
  endfunction

  function automatic logic [7:0] fflags(input logic [63:0] a, input logic [63:0] b);
    return {a[63], b[63], a[57:52] ^ b[57:52]};
  endfunction

  // Behavioral core driven only by the unpacked fields.
  assign res   = fsub({sa, ea, ma}, {sb, eb, mb});
  assign flags = fflags({sa, ea, ma}, {sb, eb, mb});

  fp_sub_cdb_unit #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_a(in_a), .in_b(in_b),
    .sa(sa), .sb(sb), .ea(ea), .eb(eb), .ma(ma), .mb(mb),
    .res(res), .flags(flags),
    .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_flags(cdb_flags), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes at the negedge, then land 1 time unit past the posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_acc = in_valid && in_ready && !rst && !flush;
    if (rst || flush) begin
      sbq.delete();
    end else begin
      if (cdb_valid && cdb_grant) begin
        checks++;
        assert (sbq.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow: observed CDB pop tag %h with %0d expected, required >=1",
                 cdb_tag, sbq.size());
        end
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
          chk("cdb_data", cdb_data, e.data);
          chk("cdb_flags", 64'(cdb_flags), 64'(e.fl));
        end
        pops++;
      end
      if (last_acc) sbq.push_back('{tag: in_tag, data: fsub(in_a, in_b), fl: fflags(in_a, in_b)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [TAG_W-1:0] t, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    in_tag   = t;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_tag = '0; in_a = '0; in_b = '0; cdb_grant = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fields", {sa, sb, ea, eb, 11'd0, 30'd0}, 64'd0);
    chk("rst_mant", 64'(ma) | 64'(mb), 64'd0);
    chk("rst_cdb_data", cdb_data, 64'd0);

    // Unpack
    drive(4'd0, 64'hC008000000000000, 64'h3FF0000000000000);
    tick();
    chk("unpack_acc", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    chk("unpack_sa", 64'(sa), 64'd1);
    chk("unpack_ea", 64'(ea), 64'h400);
    chk("unpack_ma", 64'(ma), 64'h8000000000000);
    chk("unpack_sb", 64'(sb), 64'd0);
    chk("unpack_eb", 64'(eb), 64'h3FF);
    chk("unpack_mb", 64'(mb), 64'd0);
    chk("unpack_cdb_k1", 64'(cdb_valid), 64'd0);
    cdb_grant = 1'b1;
    tick();
    chk("unpack_cdb_k2", 64'(cdb_valid), 64'd1);
    chk("unpack_data", cdb_data, 64'hC010000000000000);
    tick();
    chk("unpack_drained", 64'(cdb_valid), 64'd0);

    // Latency: 3.0 - 1.0
    drive(4'd5, 64'h4008000000000000, 64'h3FF0000000000000);
    tick();
    in_valid = 1'b0;
    chk("lat_k1_valid", 64'(cdb_valid), 64'd0);
    chk("lat_k1_busy", 64'(busy), 64'd1);
    tick();
    chk("lat_k2_valid", 64'(cdb_valid), 64'd1);
    chk("lat_k2_tag", 64'(cdb_tag), 64'd5);
    chk("lat_k2_data", cdb_data, 64'h4000000000000000);
    tick();
    chk("lat_k3_valid", 64'(cdb_valid), 64'd0);

    // Backpressure: tags 1..3 fill queue + stage 1, tag 4 stalls
    cdb_grant = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive(TAG_W'(t), $realtobits(real'(t) * 2.5), $realtobits(0.5));
      tick();
      chk("bp_acc", 64'(last_acc), 64'd1);
    end
    drive(4'd4, $realtobits(7.25), $realtobits(-1.5));
    #1;
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("bp_stall", 64'(last_acc), 64'd0);
      chk("bp_ready_hold", 64'(in_ready), 64'd0);
      chk("bp_head_tag", 64'(cdb_tag), 64'd1);
      chk("bp_head_data", cdb_data, $realtobits(2.5) ^ 64'd0 ? fsub($realtobits(2.5), $realtobits(0.5)) : 64'd0);
      chk("bp_count", 64'(dut.count_q), 64'd2);
    end
    cdb_grant = 1'b1;
    p0 = pops;
    tick();
    chk("bp_acc4", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("bp_consecutive", 64'(pops - p0), 64'd4);
    chk("bp_drained", 64'(cdb_valid), 64'd0);

    // Full queue with simultaneous grant
    cdb_grant = 1'b0;
    for (int t = 6; t <= 8; t++) begin
      drive(TAG_W'(t), $realtobits(real'(t)), $realtobits(0.25));
      tick();
    end
    drive(4'd9, $realtobits(9.0), $realtobits(4.5));
    cdb_grant = 1'b1;
    #1;
    chk("full_grant_ready", 64'(in_ready), 64'd1);
    tick();
    chk("full_grant_acc", 64'(last_acc), 64'd1);
    chk("full_grant_count", 64'(dut.count_q), 64'd2);
    chk("full_grant_head", 64'(cdb_tag), 64'd7);

    // Flush with 2 queued + 1 in stage 1 and a handshake offered
    cdb_grant = 1'b0;
    flush = 1'b1;
    drive(4'd10, $realtobits(10.0), $realtobits(1.0));
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_cdb_data", cdb_data, 64'd0);

    // Spurious grants on an empty queue
    cdb_grant = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("spur_count", 64'(dut.count_q), 64'd0);
      chk("spur_ptrs", 64'({dut.rd_ptr_q, dut.wr_ptr_q}), 64'd0);
      chk("spur_valid", 64'(cdb_valid), 64'd0);
    end
    drive(4'd11, $realtobits(-2.0), $realtobits(3.0));
    tick();
    in_valid = 1'b0;
    chk("spur_k1", 64'(cdb_valid), 64'd0);
    tick();
    chk("spur_k2_valid", 64'(cdb_valid), 64'd1);
    chk("spur_k2_tag", 64'(cdb_tag), 64'd11);
    tick();

    // Randomized traffic with occasional flush
    for (int n = 0; n < 300; n++) begin
      drive(TAG_W'($urandom), {1'($urandom), 11'(1013 + $urandom_range(0, 20)), 52'({$urandom, $urandom})},
            {1'($urandom), 11'(1013 + $urandom_range(0, 20)), 52'({$urandom, $urandom})});
      in_valid  = 1'($urandom_range(0, 2) != 0);
      cdb_grant = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    chk("final_sb_empty", 64'(sbq.size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_sub_cdb_unit.md
# fp_sub_cdb_unit

Sequential wrapper that turns the combinational double-precision subtractor core into a Tomasulo functional unit. Accepts packed 64-bit IEEE-754 operand pairs with a reservation-station tag over a valid/ready handshake, unpacks them into sign/exponent/mantissa fields that drive the core, and captures the packed result and flags. Results are broadcast in order on the common data bus (CDB) through a small output queue with grant-based backpressure.

## Interface
- TAG_W, 4, reservation-station tag width
- DEPTH, 2, output queue entries (power of two, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of all in-flight work
- in_valid  in  1  operand pair offered
- in_ready  out  1  unit can accept this cycle
- in_tag  in  TAG_W  destination tag
- in_a  in  64  minuend, packed {sign, exp[10:0], mant[51:0]}
- in_b  in  64  subtrahend, same packing
- sa, sb  out  1 each  operand signs to core
- ea, eb  out  11 each  operand exponents to core
- ma, mb  out  52 each  operand mantissas to core
- res  in  64  packed result from core
- flags  in  8  flags from core
- cdb_valid  out  1  head result on CDB
- cdb_grant  in  1  CDB arbiter accepts head this cycle
- cdb_tag  out  TAG_W  tag of head
- cdb_data  out  64  result of head
- cdb_flags  out  8  flags of head
- busy  out  1  stage 1 occupied or queue non-empty

## Operation
- Stage 1 (operand register): on in_valid && in_ready, latch sa=in_a[63], ea=in_a[62:52], ma=in_a[51:0], likewise b, and in_tag; s1_valid←1. Core outputs sa..mb are exactly these registers; no combinational path from in_* to core ports.
- Stage 2 (output queue): FIFO of DEPTH entries {tag, res, flags}. Push when s1_valid && (count<DEPTH || pop). Push captures res/flags as presented by the core during that cycle.
- s1 advances when pushed or empty. in_ready = !s1_valid || push (same-cycle refill allowed).
- Pop when cdb_valid && cdb_grant. cdb_valid = (count≠0). cdb_tag/data/flags = head entry; held stable while cdb_valid && !cdb_grant.
- Count: +1 on push only, −1 on pop only, unchanged on both. Read/write pointers wrap modulo DEPTH.
- Results leave in acceptance order; no reordering, no bypass of the queue.
- Data fields are pass-through; no arithmetic in this block. Flags are not interpreted.
- cdb_grant while cdb_valid=0: ignored, no state change.

## Timing
- Reset/flush (both synchronous, same effect, rst priority irrelevant): s1_valid=0, count=0, pointers=0, cdb_valid=0, busy=0, in_ready=1 in the following cycle; sa..mb, cdb_tag/data/flags reset to 0. Handshake or grant in the flush cycle is discarded.
- Latency: accept at edge k → core fields valid in cycle k+1 → queue push at edge k+1 → cdb_valid=1 in cycle k+2 (queue was empty). Minimum 2 cycles in→CDB.
- Throughput: one result per cycle with cdb_grant held high.
- Queue full, no grant: no push; s1 holds; in_ready=0 while s1_valid.
- Queue full with grant: push and pop same edge, count unchanged, in_ready=1.
- Stage 1 empty: in_ready=1 regardless of queue state.
- Backpressure stable: once in_ready=0, it stays 0 until a pop occurs or flush/rst.

## Test plan
- Unpack: in_a=0xC008000000000000, in_b=0x3FF0000000000000 accepted at edge k → cycle k+1 sa=1, ea=0x400, ma=0x8000000000000, sb=0, eb=0x3FF, mb=0.
- Latency: in_a=0x4008000000000000 (3.0), in_b=0x3FF0000000000000 (1.0), tag=5, grant=1 → cycle k+2 cdb_valid=1, cdb_tag=5, cdb_data=0x4000000000000000; cdb_valid=0 next cycle.
- Backpressure: grant=0, offer 4 ops (tags 1..4) back-to-back → tags 1,2 queued, tag 3 in stage 1, in_ready=0, tag 4 stalls; then grant=1 each cycle → tags 1,2,3,4 on consecutive cycles, data stable while ungranted.
- Full + simultaneous grant: queue full, s1_valid=1, grant=1 → count stays 2, in_ready=1, new op accepted same cycle.
- Flush mid-stream: 2 queued + 1 in stage 1, assert flush with in_valid=1 → next cycle cdb_valid=0, busy=0, in_ready=1; flushed op never appears on CDB.
- Spurious grant: cdb_grant=1 with empty queue for 3 cycles → count stays 0, pointers unchanged, then one op arrives at correct cycle.
